// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Handshaked data-memory target for the core's load/store port. Accepts one
//   request at a time over a valid/ready handshake, then returns a response
//   exactly LATENCY cycles after the accept edge. Loads and stores are sized
//   by the RISC-V funct3 field (B/H/W with signed and unsigned load variants).
//
//   Optional build macro: MISALIGN_TRAP_EN
//     defined   - misaligned H/HU/W accesses and funct3 011/110/111 return an
//                 error response (rsp_err=1, rsp_rdata=0, no array write).
//     undefined - rsp_err is constant 0; misaligned low address bits are
//                 forced down and the unused funct3 codes act as word accesses.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of 2, >= 4)
//   LATENCY      cycles from accept edge to rsp_valid high (>= 1)
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous active-high reset
//   req_valid    request present
//   req_ready    responder can accept (IDLE and not in reset)
//   req_we       1 = store, 0 = load
//   req_funct3   access size / signedness
//   req_addr     byte address (upper bits beyond the array alias)
//   req_wdata    right-aligned store data
//   rsp_valid    response present
//   rsp_ready    requester takes the response
//   rsp_rdata    sized and extended load data, 0 for stores
//   rsp_err      error response flag
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Request captured on the accept edge; only the bits that index the array
  // are kept, the rest of the address aliases.
  logic             lat_we;
  logic [2:0]       lat_funct3;
  logic [AW+1:0]    lat_addr;
  logic [31:0]      lat_wdata;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign req_ready = (state == S_IDLE) && !reset;

  // The edge that ends the wait window is the commit edge: the array is
  // written or sampled and the response becomes visible on that same edge.
  logic commit;
  assign commit = (state == S_WAIT) && (cnt == '0);

  // ---------------------------------------------------------------------------
  // Access decode from the captured request
  // ---------------------------------------------------------------------------
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          is_byte;
  logic          is_half;
  logic          is_unsigned;
  logic          err_c;

  assign word_idx    = lat_addr[AW+1:2];
  assign lane        = lat_addr[1:0];
  assign is_byte     = (lat_funct3[1:0] == 2'b00);
  assign is_half     = (lat_funct3[1:0] == 2'b01);
  // funct3 110 has bit 2 set but is a word access, so this only matters for
  // the byte/half paths below.
  assign is_unsigned = lat_funct3[2];

`ifdef MISALIGN_TRAP_EN
  assign err_c = (lat_funct3 == 3'b011) || (lat_funct3 == 3'b110) ||
                 (lat_funct3 == 3'b111) ||
                 (is_half && lat_addr[0]) ||
                 (!is_byte && !is_half && (lat_addr[1:0] != 2'b00));
`else
  assign err_c = 1'b0;
`endif

  logic [31:0] rd_word;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic [31:0] wr_data;

  assign rd_word  = mem[word_idx];
  assign byte_val = rd_word[{lane, 3'b000} +: 8];
  // Half lane is chosen by addr[1] alone, which forces misaligned halves down.
  assign half_val = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise the tool infers a latch to hold the old value.
  always_comb begin
    load_data = rd_word;
    byte_en   = 4'b1111;
    wr_data   = lat_wdata;
    if (is_byte) begin
      load_data = {{24{byte_val[7] & ~is_unsigned}}, byte_val};
      byte_en   = 4'b0001 << lane;
      wr_data   = {4{lat_wdata[7:0]}};
    end else if (is_half) begin
      load_data = {{16{half_val[15] & ~is_unsigned}}, half_val};
      byte_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
      wr_data   = {2{lat_wdata[15:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Array write port
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; contents survive reset and clearing
  // it would turn a RAM into thousands of resettable flops.
  always_ff @(posedge clk) begin
    if (!reset && commit && lat_we && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered response outputs
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge value of every other register, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr[AW+1:0];
            lat_wdata  <= req_wdata;
            // Counter holds the number of further WAIT cycles; with
            // LATENCY==1 it starts at zero and the next edge commits.
            cnt        <= CNT_W'(LATENCY - 1);
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (commit) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= (lat_we || err_c) ? '0 : load_data;
            rsp_err   <= err_c;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Each request pushes its expected
//   response into a queue computed from a reference word array; the response
//   side pops and compares. Covers reset state, latency, byte/half/word sizing,
//   back-pressure, address aliasing, reset during a pending store, and the
//   misaligned/unused-funct3 behaviour for whichever build is compiled.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 64;
  localparam int LATENCY     = 2;
  localparam int AW          = $clog2(DEPTH_WORDS);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_X3 = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] model [DEPTH_WORDS];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour ------------------------------------------------------
  function automatic bit model_err(input logic [2:0] f3, input logic [31:0] a);
    bit bad;
    case (f3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      3'b001, 3'b101:         bad = a[0];
      3'b010:                 bad = (a[1:0] != 2'b00);
      default:                bad = 1'b0;
    endcase
    return bad & TRAP;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model[a[AW+1:2]];
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F_B:     return 32'($signed(b));
      F_BU:    return {24'h0, b};
      F_H:     return 32'($signed(h));
      F_HU:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    w = model[a[AW+1:2]];
    case (f3)
      F_B, F_BU: w[8*a[1:0] +: 8] = d[7:0];
      F_H, F_HU: w[16*a[1] +: 16] = d[15:0];
      default:   w = d;
    endcase
    model[a[AW+1:2]] = w;
  endtask

  // Drive one request and wait for its accept edge. With track=0 the
  // request is expected never to complete (nothing queued, model untouched).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit track);
    int   n;
    rsp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_at_issue", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    if (track) begin
      e.err   = model_err(f3, a);
      e.rdata = (we || e.err) ? 32'h0 : model_load(f3, a);
      exp_q.push_back(e);
      if (we && !e.err) model_store(f3, a, d);
    end
    @(posedge clk);
    #1;
    // Garbage on the request bus must be ignored outside IDLE.
    req_valid  = 1'b0;
    req_we     = 1'b1;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hFFFF_FFFF;
  endtask

  // Wait for the response of the last issued request, hold it for 'hold'
  // cycles of back-pressure, then complete the handshake.
  task automatic collect(input string tag, input int hold);
    int   n;
    rsp_t e;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!rsp_valid && n < 20);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_latency"}, n, LATENCY);
    check({tag, "_busy"}, req_ready, 0);
    e = exp_q.pop_front();
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, rsp_err, e.err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_hold_busy"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_done_valid"}, rsp_valid, 0);
    check({tag, "_done_rdata"}, rsp_rdata, 0);
    check({tag, "_done_err"}, rsp_err, 0);
    check({tag, "_done_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);

    // Word store then load
    issue(1'b1, F_W, 32'h10, 32'hDEADBEEF, 1'b1);
    collect("sw_10", 0);
    issue(1'b0, F_W, 32'h10, 32'h0, 1'b1);
    collect("lw_10", 0);

    // Byte store, signed/unsigned byte loads, word read-back
    issue(1'b1, F_B, 32'h11, 32'h00000080, 1'b1);
    collect("sb_11", 0);
    issue(1'b0, F_B, 32'h11, 32'h0, 1'b1);
    collect("lb_11", 0);
    issue(1'b0, F_BU, 32'h11, 32'h0, 1'b1);
    collect("lbu_11", 0);
    issue(1'b0, F_W, 32'h10, 32'h0, 1'b1);
    collect("lw_10b", 0);

    // Back-pressure: response held for 5 cycles
    issue(1'b0, F_H, 32'h12, 32'h0, 1'b1);
    collect("lh_hold", 5);

    // Aliasing wrap-around
    issue(1'b1, F_W, 32'h100, 32'h12345678, 1'b1);
    collect("sw_100", 0);
    issue(1'b0, F_W, 32'h000, 32'h0, 1'b1);
    collect("lw_alias", 0);

    // Reset while a store is waiting to commit
    issue(1'b1, F_W, 32'h20, 32'h11111111, 1'b1);
    collect("sw_20", 0);
    issue(1'b1, F_W, 32'h20, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_rsp_valid", rsp_valid, 0);
    end
    issue(1'b0, F_W, 32'h20, 32'h0, 1'b1);
    collect("lw_20_kept", 0);

    // Misaligned and unused-funct3 accesses (trap or force-down per build)
    issue(1'b1, F_W, 32'h24, 32'hA5A55A5A, 1'b1);
    collect("sw_24", 0);
    issue(1'b1, F_W, 32'h22, 32'h0BADF00D, 1'b1);
    collect("sw_22_mis", 0);
    issue(1'b0, F_W, 32'h20, 32'h0, 1'b1);
    collect("lw_20_after", 0);
    issue(1'b0, F_W, 32'h22, 32'h0, 1'b1);
    collect("lw_22_mis", 0);
    issue(1'b0, F_H, 32'h26, 32'h0, 1'b1);
    collect("lh_26", 0);
    issue(1'b0, F_HU, 32'h27, 32'h0, 1'b1);
    collect("lhu_27_mis", 0);
    issue(1'b0, F_B, 32'h27, 32'h0, 1'b1);
    collect("lb_27", 0);
    issue(1'b0, F_X3, 32'h24, 32'h0, 1'b1);
    collect("l011_24", 0);
    issue(1'b1, F_H, 32'h25, 32'h0000BEEF, 1'b1);
    collect("sh_25_mis", 0);
    issue(1'b0, F_W, 32'h24, 32'h0, 1'b1);
    collect("lw_24_final", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
